soc_onchip_memory_arbiter: RTL and testbench
============================================

# soc_onchip_memory_arbiter

Two-master arbiter and clear sequencer for the 4096 x 16 single-port on-chip RAM. It sits between two Avalon-MM-style requesters (CPU data port and DMA/video master) and the RAM's single slave port. It issues at most one access per cycle, routes read data back to the owning master with fixed one-cycle latency, and can sweep the whole RAM to zero on request.

## Interface
Parameters:
- ADDR_W, 12, word address width
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)
- DEPTH, 4096, words swept by clear; equals 2**ADDR_W

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  write byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, wired to mem_readdata
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid strobe
- clear_req  in  1  level; start RAM zero sweep
- clear_busy  out  1  sweep in progress
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byteenable
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM q (address registered, output unregistered)

## Operation
- States: ARB, CLEAR. Reset state is ARB.
- In ARB, a master requests when read|write is high. If both read and write are high, the write is performed and the read is ignored.
- Arbitration with SOC_OCM_ARB_RR_EN defined: round-robin.
  - A 1-bit last-grant pointer resets to 1, so m0 wins the first contention.
  - When both masters request, grant goes to ~last.
  - The pointer updates on every grant.
- Granted master: waitrequest=0. The mem_* outputs carry its address, byteenable and writedata, with mem_chipselect=1 and mem_write=its write.
- Non-granted or idle master: waitrequest=1.
- No request: mem_chipselect=0, mem_write=0.
- Read pipeline:
  - rd_pend and rd_owner registers capture each granted read.
  - In the next cycle, the owner's readdatavalid=1. The other master's readdatavalid=0.
- Throughput: one access per cycle. Back-to-back reads from alternating masters are legal; each readdatavalid follows its own grant by exactly one cycle.
- CLEAR is entered when clear_req=1 is sampled in ARB. The request arriving in that same cycle is still arbitrated normally.
- In CLEAR:
  - Both waitrequest=1.
  - mem_chipselect=1, mem_write=1, mem_byteenable=all ones, mem_writedata=0, mem_address=clr_cnt.
  - clr_cnt starts at 0 and increments each cycle.
  - After address DEPTH-1 is written, clr_cnt wraps to 0 and the state returns to ARB.
- clear_busy=1 exactly while in CLEAR. clear_req is ignored in CLEAR. A still-high clear_req in ARB restarts the sweep.
- A read granted in the cycle CLEAR is entered still gets its readdatavalid in the next cycle.
- Reset, including mid-sweep: state=ARB, clr_cnt=0, last=1, rd_pend=0. The partial sweep is abandoned.

## Timing
- Reset values:
  - m*_waitrequest=1.
  - m*_readdatavalid=0, clear_busy=0.
  - mem_chipselect=0, mem_write=0.
  - mem_address=0, mem_byteenable=0, mem_writedata=0.
  - m*_readdata follows mem_readdata.
- waitrequest and all mem_* outputs are combinational from the requests, state and pointer. Masters hold their request until waitrequest=0.
- Read latency: grant in cycle N gives readdatavalid and valid readdata in N+1.
- Write completes at the grant edge; no response.
- Clear duration: clear_req sampled at edge E. clear_busy is high for DEPTH cycles starting at E, and masters can be granted again in cycle E+DEPTH.

## Configuration
- SOC_OCM_ARB_RR_EN defined: round-robin arbitration as above.
- Undefined: fixed priority, m0 always wins contention. The last-grant pointer is not built. m1 can starve under continuous m0 traffic.

## Test plan
- Single read: m0 writes 0x1234 to 0x010 with byteenable 11, then reads 0x010. Expect m0_waitrequest=0 on both accesses. m0_readdatavalid pulses one cycle after the read grant with m0_readdata=0x1234, and m1_readdatavalid stays 0.
- Byte lanes: write 0xABCD to 0x020, then 0x00EF with byteenable 01. A read returns 0xABEF.
- Contention, RR build: m0 and m1 both read continuously. Grants alternate m0, m1, m0, m1, starting with m0. Each readdatavalid goes to the correct master one cycle after its grant.
- Contention, fixed build: same stimulus. m0 is granted every cycle and m1_waitrequest stays 1.
- Clear: preload 0x0FFF=0x5555 and 0x0000=0x7777, pulse clear_req for 1 cycle. clear_busy is high for 4096 cycles and requests stall during it. Afterwards both addresses read 0x0000.
- Reset mid-clear: assert reset_n=0 at sweep cycle 100. clear_busy drops immediately, address 0x0FFF retains its old value, and the next grant goes to m0.

Source files
------------

// File: rtl/soc_onchip_memory_arbiter.sv
// Two-master arbiter and zero-sweep sequencer for a single-port on-chip RAM.
// Optional feature macro: SOC_OCM_ARB_RR_EN (round-robin arbitration; fixed m0 priority otherwise).
module soc_onchip_memory_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int BE_W   = 2,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [ADDR_W-1:0] w_clr_cnt_nxt;
   logic              r_rd_pend;
   logic              r_rd_owner;
   logic              w_m0_req;
   logic              w_m1_req;
   logic              w_gnt_vld;
   logic              w_gnt_sel;
   logic              w_gnt_rd;

   assign w_m0_req = m0_read | m0_write;
   assign w_m1_req = m1_read | m1_write;

`ifdef SOC_OCM_ARB_RR_EN
   // last = 1 means m1 was granted last, so m0 wins the first contention after reset
   logic r_last;

   // Round-robin pointer, updated on every grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= 1'b1;
      end else if (w_gnt_vld) begin
         r_last <= w_gnt_sel;
      end else begin
         r_last <= r_last;
      end
   end
`endif

   // Grant selection: only in ARB; a write wins over a simultaneous read of the same master
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_sel = 1'b0;
      w_gnt_rd  = 1'b0;
      if (r_state == ST_ARB) begin
         w_gnt_vld = w_m0_req | w_m1_req;
         if (w_m0_req && w_m1_req) begin
`ifdef SOC_OCM_ARB_RR_EN
            w_gnt_sel = ~r_last;
`else
            w_gnt_sel = 1'b0;
`endif
         end else begin
            w_gnt_sel = w_m1_req;
         end
         if (w_gnt_sel) begin
            w_gnt_rd = w_gnt_vld & m1_read & ~m1_write;
         end else begin
            w_gnt_rd = w_gnt_vld & m0_read & ~m0_write;
         end
      end else begin
         w_gnt_vld = 1'b0;
      end
   end

   // RAM port mux and master handshakes
   always_comb begin
      mem_address    = {ADDR_W{1'b0}};
      mem_byteenable = {BE_W{1'b0}};
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = {DATA_W{1'b0}};
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      clear_busy     = 1'b0;
      case (r_state)
         ST_ARB: begin
            if (w_gnt_vld) begin
               mem_chipselect = 1'b1;
               if (w_gnt_sel) begin
                  m1_waitrequest = 1'b0;
                  mem_address    = m1_address;
                  mem_byteenable = m1_byteenable;
                  mem_write      = m1_write;
                  mem_writedata  = m1_writedata;
               end else begin
                  m0_waitrequest = 1'b0;
                  mem_address    = m0_address;
                  mem_byteenable = m0_byteenable;
                  mem_write      = m0_write;
                  mem_writedata  = m0_writedata;
               end
            end else begin
               mem_chipselect = 1'b0;
            end
         end
         ST_CLEAR: begin
            clear_busy     = 1'b1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = {BE_W{1'b1}};
            mem_address    = r_clr_cnt;
         end
         default: begin
            clear_busy = 1'b0;
         end
      endcase
   end

   // Next state and sweep counter
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_ARB: begin
            if (clear_req) begin
               w_state_nxt = ST_CLEAR;
            end else begin
               w_state_nxt = ST_ARB;
            end
         end
         ST_CLEAR: begin
            if (r_clr_cnt == CLR_LAST) begin
               w_clr_cnt_nxt = {ADDR_W{1'b0}};
               w_state_nxt   = ST_ARB;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
               w_state_nxt   = ST_CLEAR;
            end
         end
         default: begin
            w_state_nxt   = ST_ARB;
            w_clr_cnt_nxt = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, sweep counter and read-return pipeline registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_ARB;
         r_clr_cnt  <= {ADDR_W{1'b0}};
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_cnt  <= w_clr_cnt_nxt;
         r_rd_pend  <= w_gnt_rd;
         r_rd_owner <= w_gnt_sel;
      end
   end

   assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
   assign m1_readdatavalid = r_rd_pend &  r_rd_owner;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_soc_onchip_memory_arbiter.sv
// Directed self-checking bench for soc_onchip_memory_arbiter with a behavioural 4096x16 RAM.
// Follows SOC_OCM_ARB_RR_EN to pick round-robin or fixed-priority expectations.
module tb_soc_onchip_memory_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] m0_address, m1_address;
   logic [1:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [15:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [15:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        clear_req;
   logic        clear_busy;
   logic [11:0] mem_address;
   logic [1:0]  mem_byteenable;
   logic        mem_chipselect, mem_write;
   logic [15:0] mem_writedata, mem_readdata;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] ram [0:4095];
   logic [11:0] ram_addr = 12'd0;

   soc_onchip_memory_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .clear_req(clear_req), .clear_busy(clear_busy),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
   end

   // RAM model: registered address, unregistered q, byte-lane writes
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write && mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
         if (mem_write && mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
         ram_addr <= mem_address;
      end
   end
   assign mem_readdata = ram[ram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic rd, input logic wr, input logic [11:0] a,
                       input logic [1:0] be, input logic [15:0] wd);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
   endtask

   task automatic drv1(input logic rd, input logic wr, input logic [11:0] a,
                       input logic [1:0] be, input logic [15:0] wd);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
   endtask

   task automatic idle;
      drv0(1'b0, 1'b0, 12'h000, 2'b00, 16'h0000);
      drv1(1'b0, 1'b0, 12'h000, 2'b00, 16'h0000);
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic exp_m0_gnt, prev_m0_gnt;
   int   busy_cnt;
   logic done;

   initial begin
      idle();
      clear_req = 1'b0;
      reset_n   = 1'b0;
      #12;
      check("rst_m0_wait", m0_waitrequest, 1);
      check("rst_m1_wait", m1_waitrequest, 1);
      check("rst_m0_rdv", m0_readdatavalid, 0);
      check("rst_m1_rdv", m1_readdatavalid, 0);
      check("rst_busy", clear_busy, 0);
      check("rst_cs", mem_chipselect, 0);
      check("rst_wr", mem_write, 0);
      check("rst_addr", mem_address, 0);
      check("rst_be", mem_byteenable, 0);
      check("rst_wd", mem_writedata, 0);
      check("rst_rdata", m0_readdata, mem_readdata);

      // single write then read on m0
      nxt(); reset_n = 1'b1;
      drv0(1'b0, 1'b1, 12'h010, 2'b11, 16'h1234); settle();
      check("wr_m0_wait", m0_waitrequest, 0);
      check("wr_cs", mem_chipselect, 1);
      check("wr_we", mem_write, 1);
      check("wr_addr", mem_address, 12'h010);
      check("wr_wd", mem_writedata, 16'h1234);
      nxt(); drv0(1'b1, 1'b0, 12'h010, 2'b11, 16'h0000); settle();
      check("rd_m0_wait", m0_waitrequest, 0);
      check("rd_we", mem_write, 0);
      check("rd_rdv_early", m0_readdatavalid, 0);
      nxt(); idle(); settle();
      check("rd_m0_rdv", m0_readdatavalid, 1);
      check("rd_m0_data", m0_readdata, 16'h1234);
      check("rd_m1_rdv", m1_readdatavalid, 0);
      nxt(); settle();
      check("rd_rdv_once", m0_readdatavalid, 0);

      // byte lanes, plus read-write priority: write wins when both strobes are high
      drv0(1'b0, 1'b1, 12'h020, 2'b11, 16'hABCD);
      nxt(); drv0(1'b1, 1'b1, 12'h020, 2'b01, 16'h00EF); settle();
      check("be_rw_we", mem_write, 1);
      nxt(); drv0(1'b1, 1'b0, 12'h020, 2'b11, 16'h0000);
      settle();
      check("be_rw_no_rdv", m0_readdatavalid, 0);
      nxt(); idle(); settle();
      check("be_data", m0_readdata, 16'hABEF);
      check("be_rdv", m0_readdatavalid, 1);

      // contention, from a fresh pointer
      nxt(); reset_n = 1'b0; settle();
      nxt(); reset_n = 1'b1;
      prev_m0_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) nxt();
         drv0(1'b1, 1'b0, 12'h010, 2'b11, 16'h0000);
         drv1(1'b1, 1'b0, 12'h020, 2'b11, 16'h0000);
         settle();
`ifdef SOC_OCM_ARB_RR_EN
         exp_m0_gnt = ((k % 2) == 0);
`else
         exp_m0_gnt = 1'b1;
`endif
         check("cont_m0_wait", m0_waitrequest, !exp_m0_gnt);
         check("cont_m1_wait", m1_waitrequest, exp_m0_gnt);
         check("cont_addr", mem_address, exp_m0_gnt ? 12'h010 : 12'h020);
         if (k > 0) begin
            check("cont_m0_rdv", m0_readdatavalid, prev_m0_gnt);
            check("cont_m1_rdv", m1_readdatavalid, !prev_m0_gnt);
            check("cont_rdata", m0_readdata, prev_m0_gnt ? 16'h1234 : 16'hABEF);
         end
         prev_m0_gnt = exp_m0_gnt;
      end
      nxt(); idle(); settle();
      check("cont_last_m0_rdv", m0_readdatavalid, prev_m0_gnt);
      check("cont_last_m1_rdv", m1_readdatavalid, !prev_m0_gnt);

      // clear sweep: preload through m1, enter CLEAR with a concurrent m0 read
      nxt(); drv1(1'b0, 1'b1, 12'hFFF, 2'b11, 16'h5555); settle();
      check("pre_m1_wait", m1_waitrequest, 0);
      nxt(); drv1(1'b0, 1'b1, 12'h000, 2'b11, 16'h7777);
      nxt(); idle(); clear_req = 1'b1;
      drv0(1'b1, 1'b0, 12'hFFF, 2'b11, 16'h0000); settle();
      check("clr_entry_m0_wait", m0_waitrequest, 0);
      check("clr_entry_busy", clear_busy, 0);
      nxt(); clear_req = 1'b0; idle();
      drv1(1'b0, 1'b1, 12'h100, 2'b11, 16'h0BAD); settle();
      check("clr_busy0", clear_busy, 1);
      check("clr_entry_rdv", m0_readdatavalid, 1);
      check("clr_entry_rdata", m0_readdata, 16'h5555);
      check("clr_m1_stall", m1_waitrequest, 1);
      check("clr_addr0", mem_address, 12'h000);
      check("clr_we", mem_write, 1);
      check("clr_be", mem_byteenable, 2'b11);
      check("clr_wd", mem_writedata, 16'h0000);
      busy_cnt = 1;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         nxt(); settle();
         if (clear_busy) begin
            if (busy_cnt == 2048) check("clr_addr_mid", mem_address, 12'd2048);
            if (busy_cnt == 2048) check("clr_m1_stall_mid", m1_waitrequest, 1);
            busy_cnt++;
         end else begin
            done = 1'b1;
         end
      end
      check("clr_duration", busy_cnt, 4096);
      check("clr_exit_m1_wait", m1_waitrequest, 0);
      check("clr_exit_addr", mem_address, 12'h100);
      nxt(); idle(); drv0(1'b1, 1'b0, 12'hFFF, 2'b11, 16'h0000);
      nxt(); drv0(1'b1, 1'b0, 12'h000, 2'b11, 16'h0000); settle();
      check("clr_fff_zero", m0_readdata, 16'h0000);
      nxt(); idle(); settle();
      check("clr_000_zero", m0_readdata, 16'h0000);
      check("clr_000_rdv", m0_readdatavalid, 1);

      // reset during a sweep abandons it
      nxt(); drv0(1'b0, 1'b1, 12'hFFF, 2'b11, 16'h5555);
      nxt(); idle(); clear_req = 1'b1;
      nxt(); clear_req = 1'b0;
      for (int i = 0; i < 100; i++) nxt();
      settle();
      check("mid_addr100", mem_address, 12'd100);
      check("mid_busy", clear_busy, 1);
      reset_n = 1'b0; settle();
      check("mid_rst_busy", clear_busy, 0);
      check("mid_rst_cs", mem_chipselect, 0);
      check("mid_rst_m0_wait", m0_waitrequest, 1);
      nxt(); reset_n = 1'b1;
      drv0(1'b1, 1'b0, 12'hFFF, 2'b11, 16'h0000);
      drv1(1'b1, 1'b0, 12'hFFF, 2'b11, 16'h0000); settle();
      check("mid_m0_gnt", m0_waitrequest, 0);
      check("mid_m1_wait", m1_waitrequest, 1);
      check("mid_busy_after", clear_busy, 0);
      nxt(); idle(); settle();
      check("mid_fff_kept", m0_readdata, 16'h5555);
      check("mid_m0_rdv", m0_readdatavalid, 1);
      check("mid_m1_rdv", m1_readdatavalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
